// File: rtl/seq_block_cla_subtractor.sv
// Multi-cycle subtractor: D = X + ~Y + 1, evaluated one BLK-bit carry look-ahead
// block per cycle with the inter-block carry held in a register. Valid/ready on both sides.
module seq_block_cla_subtractor #(
  parameter int unsigned WIDTH = 15,
  parameter int unsigned BLK   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   d
);

  localparam int unsigned NBLK  = (WIDTH + BLK - 1) / BLK;
  localparam int unsigned LASTW = WIDTH - (NBLK - 1) * BLK;
  localparam int unsigned IDXW  = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int unsigned IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              carry_q;
  logic [IDXW-1:0]   idx_q;
  logic [WIDTH:0]    res_q;
  logic              out_valid_q;

  logic              accept;
  logic              blk_last;
  int unsigned       blk_base;
  logic [BLK-1:0]    blk_a;
  logic [BLK-1:0]    blk_b;
  logic [BLK-1:0]    blk_g;
  logic [BLK-1:0]    blk_p;
  logic [BLK:0]      blk_c;
  logic [BLK-1:0]    blk_s;
  logic [WIDTH-1:0]  sum_d;
  logic              cout_d;

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign d         = res_q;
  assign blk_last  = (idx_q == IDXW'(NBLK - 1));

  // Current block datapath; bit positions beyond WIDTH in the last block read as 0
  // (g=p=0), so the block carry-out is taken at the last valid bit.
  always_comb begin
    logic acc;
    logic term;
    blk_base = BLK * 32'(idx_q);
    blk_a    = '0;
    blk_b    = '0;
    for (int unsigned j = 0; j < BLK; j++) begin
      if (blk_base + j < WIDTH) begin
        blk_a[j] = a_q[IW'(blk_base + j)];
        blk_b[j] = b_q[IW'(blk_base + j)];
      end
    end
    blk_g    = blk_a & blk_b;
    blk_p    = blk_a ^ blk_b;
    blk_c    = '0;
    blk_c[0] = carry_q;
    for (int unsigned i = 0; i < BLK; i++) begin
      acc = carry_q;
      for (int unsigned k = 0; k <= i; k++) begin
        acc = acc & blk_p[k];
      end
      for (int unsigned j = 0; j <= i; j++) begin
        term = blk_g[j];
        for (int unsigned k = j + 1; k <= i; k++) begin
          term = term & blk_p[k];
        end
        acc = acc | term;
      end
      blk_c[i+1] = acc;
    end
    blk_s = blk_p ^ blk_c[BLK-1:0];
    sum_d = res_q[WIDTH-1:0];
    for (int unsigned j = 0; j < BLK; j++) begin
      if (blk_base + j < WIDTH) begin
        sum_d[IW'(blk_base + j)] = blk_s[j];
      end
    end
    cout_d = blk_last ? blk_c[LASTW] : blk_c[BLK];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      // Accept from IDLE, or consume-and-accept in the same edge from DONE.
      state_q     <= S_BUSY;
      a_q         <= x;
      b_q         <= ~y;
      carry_q     <= 1'b1;
      idx_q       <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_BUSY: begin
          res_q[WIDTH-1:0] <= sum_d;
          carry_q          <= cout_d;
          if (blk_last) begin
            res_q[WIDTH] <= cout_d;
            idx_q        <= '0;
            out_valid_q  <= 1'b1;
            state_q      <= S_DONE;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
